// File: rtl/tinyalu_pkg.sv
// rtl/tinyalu_pkg.sv - shared TinyALU serial framing types and constants
package tinyalu_pkg;

    typedef enum logic {
        DATA = 1'b0,
        CMD  = 1'b1
    } payload_type_t;

    typedef enum logic [1:0] {
        WAIT_A   = 2'd0,
        WAIT_B   = 2'd1,
        WAIT_CMD = 2'd2
    } rx_state_t;

    localparam int WORD_LEN   = 10;
    localparam int ERR_PARITY = 0;
    localparam int ERR_SEQ    = 1;
    localparam int ERR_ABORT  = 2;

endpackage

// File: rtl/tinyalu_serial_rx_if.sv
// rtl/tinyalu_serial_rx_if.sv - parallel command handshake from receiver to ALU core
interface tinyalu_serial_rx_if #(
    parameter int DATA_W = 8
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_a;
    logic [DATA_W-1:0] out_b;
    logic [DATA_W-1:0] out_op;
    logic [2:0]        out_err;

    modport master (
        output out_valid, out_a, out_b, out_op, out_err,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_a, out_b, out_op, out_err,
        output out_ready
    );
endinterface

// File: rtl/tinyalu_word_rx.sv
// rtl/tinyalu_word_rx.sv - serial word deframer: shift register, bit counter, parity check
module tinyalu_word_rx
    import tinyalu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable_n,
    input  logic              din,
    output logic              word_done,
    output payload_type_t     word_type,
    output logic [DATA_W-1:0] word_data,
    output logic              parity_err,
    output logic              abort
);
    localparam int WL = DATA_W + 2;
    localparam int CW = $clog2(WL);

    logic [WL-2:0] sr_q;
    logic [CW-1:0] cnt_q;
    logic [WL-1:0] word;

    // The final bit is taken straight from din so the word is usable on the edge that samples it.
    assign word       = {sr_q, din};
    assign word_done  = !enable_n && (cnt_q == CW'(WL - 1));
    assign word_type  = payload_type_t'(word[WL-1]);
    assign word_data  = word[WL-2:1];
    assign parity_err = ^word;
    assign abort      = enable_n && (cnt_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else if (!enable_n) begin
            sr_q  <= word[WL-2:0];
            cnt_q <= word_done ? '0 : cnt_q + CW'(1);
        end else if (abort) begin
            cnt_q <= '0;
        end
    end
endmodule

// File: rtl/tinyalu_serial_rx.sv
// rtl/tinyalu_serial_rx.sv - TinyALU serial command receiver: frame FSM and one-deep output buffer
module tinyalu_serial_rx
    import tinyalu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable_n,
    input  logic                din,
    tinyalu_serial_rx_if.master cmd,
    output logic                overrun
);
    logic              word_done;
    payload_type_t     word_type;
    logic [DATA_W-1:0] word_data;
    logic              parity_err;
    logic              abort;

    tinyalu_word_rx #(.DATA_W(DATA_W)) u_word_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable_n   (enable_n),
        .din        (din),
        .word_done  (word_done),
        .word_type  (word_type),
        .word_data  (word_data),
        .parity_err (parity_err),
        .abort      (abort)
    );

    rx_state_t         state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, op_q, op_d;
    logic [2:0]        err_q, err_d, err_acc;
    logic              deliver;

    logic              valid_q, overrun_q;
    logic [DATA_W-1:0] oa_q, ob_q, oop_q;
    logic [2:0]        oerr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= WAIT_A;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (word_done) begin
            case (state_q)
                WAIT_A:   state_d = (word_type == DATA) ? WAIT_B   : WAIT_A;
                WAIT_B:   state_d = (word_type == DATA) ? WAIT_CMD : WAIT_A;
                WAIT_CMD: state_d = (word_type == DATA) ? WAIT_CMD : WAIT_A;
                default:  state_d = WAIT_A;
            endcase
        end
    end

    // Any CMD word closes the frame; a CMD out of order still carries its opcode.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        deliver = 1'b0;
        err_acc = err_q;
        if (abort) err_acc[ERR_ABORT] = 1'b1;
        if (word_done) begin
            if (parity_err) err_acc[ERR_PARITY] = 1'b1;
            if (word_type == DATA) begin
                case (state_q)
                    WAIT_A:  a_d = word_data;
                    WAIT_B:  b_d = word_data;
                    default: err_acc[ERR_SEQ] = 1'b1;
                endcase
            end else begin
                if (state_q != WAIT_CMD) err_acc[ERR_SEQ] = 1'b1;
                op_d    = word_data;
                deliver = 1'b1;
            end
        end
        err_d = deliver ? 3'b000 : err_acc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            err_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            op_q  <= op_d;
            err_q <= err_d;
        end
    end

    // A completing frame may replace a command accepted on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            oa_q      <= '0;
            ob_q      <= '0;
            oop_q     <= '0;
            oerr_q    <= '0;
        end else begin
            overrun_q <= 1'b0;
            if (deliver && valid_q && !cmd.out_ready) begin
                overrun_q <= 1'b1;
            end else if (deliver) begin
                valid_q <= 1'b1;
                oa_q    <= a_d;
                ob_q    <= b_d;
                oop_q   <= op_d;
                oerr_q  <= err_acc;
            end else if (valid_q && cmd.out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign cmd.out_valid = valid_q;
    assign cmd.out_a     = oa_q;
    assign cmd.out_b     = ob_q;
    assign cmd.out_op    = oop_q;
    assign cmd.out_err   = oerr_q;
    assign overrun       = overrun_q;
endmodule

// File: doc/tinyalu_serial_rx.md
# tinyalu_serial_rx

Serial command receiver at the input side of the TinyALU. It takes the bit-serial `din`/`enable_n` stream from the testbench BFM and deframes it into 10-bit words, checking parity on each. It then assembles A, B and op into one parallel command and hands that command to the ALU core over a valid/ready handshake, with per-frame error flags.

## Interface
Parameters:
- `DATA_W`, 8, payload bits per word; word length is `DATA_W+2`.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `enable_n`  in  1  bit-valid strobe, active-low; `din` is sampled only while low.
- `din`  in  1  serial data, word MSB first.
- `out_valid`  out  1  command available.
- `out_ready`  in  1  core accepts command.
- `out_a`  out  DATA_W  operand A.
- `out_b`  out  DATA_W  operand B.
- `out_op`  out  DATA_W  opcode field (raw; legality checked downstream).
- `out_err`  out  3  frame error flags: [0] parity, [1] sequence, [2] abort.
- `overrun`  out  1  one-cycle pulse: completed frame dropped.

## Operation
- Word format, MSB first: bit9 = payload type (0 DATA, 1 CMD), bits 8:1 = data, bit0 = parity.
- Parity rule: bit0 must equal XOR of bits 9:1. A mismatch sets the parity flag.
- Word assembly:
  - Each rising edge with `enable_n`=0 shifts `din` in and increments the bit counter (0..9).
  - At the 10th bit the word is complete and the counter wraps to 0.
  - `enable_n` may be high between words; framing state is kept.
- Frame FSM:
  - WAIT_A:
    - DATA → store A, go to WAIT_B.
    - CMD → sequence error; deliver the frame (A and B hold their previous values); stay in WAIT_A.
  - WAIT_B:
    - DATA → store B, go to WAIT_CMD.
    - CMD → sequence error; deliver the frame; go to WAIT_A.
  - WAIT_CMD:
    - DATA → sequence error; discard the word; stay in WAIT_CMD.
    - CMD → store op, deliver the frame, go to WAIT_A.
- A word with a parity error is still classified by its bit9 and its data is stored. The parity flag travels with the frame.
- Error flags accumulate (sticky) over the frame and are cleared when the frame is delivered. Every CMD word ends a frame.
- Abort: `enable_n` rising while the bit counter is 1..9 discards the partial word, resets the counter and sets the abort flag. FSM state is unchanged.
- Output buffer is one deep.
  - A frame completing while `out_valid`=1 and `out_ready`=0 is dropped and `overrun` pulses.
  - The held command is unchanged.

## Timing
- Reset values:
  - All outputs: 0.
  - FSM: WAIT_A.
  - Bit counter: 0.
  - Error flags: 0.
- Reset mid-word or mid-frame discards everything.
- Latency: `out_valid` and all `out_*` are registered by the same edge that samples the CMD word's bit0. They are valid from the following cycle.
- Handshake:
  - A transfer occurs on an edge where `out_valid`=1 and `out_ready`=1.
  - `out_valid` falls after that edge unless a new frame completes on the same edge. In that case the new frame loads, `out_valid` stays 1, and no overrun occurs.
- `out_*` are stable while `out_valid`=1 and not accepted.
- Minimum frame: 30 sampled bits. Back-to-back frames are sustained when `out_ready`=1.

## Structure
- `tinyalu_pkg` (shared with the BFM) holds:
  - `payload_type_t` (DATA=0, CMD=1);
  - `rx_state_t` {WAIT_A, WAIT_B, WAIT_CMD};
  - constants `WORD_LEN`=10 and error bit indices `ERR_PARITY`=0, `ERR_SEQ`=1, `ERR_ABORT`=2.
- Sub-module `tinyalu_word_rx`:
  - contents: shift register, bit counter and parity check;
  - outputs: `word_done` pulse, `word_type`, `word_data`, `parity_err`, `abort`.
- The top level holds the frame FSM, the output buffer and the handshake.

## Test plan
- Words 0_0x05_0, 0_0x03_0, 1_0x01_0 with `out_ready`=1 → `out_valid` high 1 cycle after the last bit; A=0x05, B=0x03, op=0x01, `out_err`=000.
- Same frame with A's parity bit flipped to 1 → A=0x05, B=0x03, op=0x01, `out_err`=001.
- CMD 1_0x01_0 sent first, then a full valid frame → first delivery `out_err`=010; second frame A=0x05, B=0x03, op=0x01, `out_err`=000.
- `enable_n` raised after 4 bits of A, then a full valid frame → `out_err`=100 with A=0x05, B=0x03, op=0x01.
- `out_ready`=0, two consecutive valid frames (second A=0x0A, B=0x0B, op=0x02) → `overrun` pulses once; held output is still A=0x05, B=0x03, op=0x01.
- `rst_n` low for 1 cycle mid-B word, then a full valid frame → no delivery before it; then A=0x05, B=0x03, op=0x01, `out_err`=000.
